// File: rtl/npu_window_feeder_pkg.sv
// Shared defaults, state encoding and pixel/column/window types for the
// NPU window feeder.
package npu_pkg;

  localparam int NPU_N          = 10;
  localparam int NPU_K_SIZE     = 3;
  localparam int NPU_DATA_WIDTH = 8;
  localparam int NPU_COLS       = NPU_N + NPU_K_SIZE - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } feeder_state_t;

  typedef logic [NPU_DATA_WIDTH-1:0] pix_t;
  typedef pix_t [NPU_K_SIZE-1:0]     col_t;
  typedef col_t [NPU_K_SIZE-1:0]     win_t;

  // Window index width; a single-window job still needs one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/npu_window_feeder_if.sv
// Column-in / window-out handshake bundle between the column buffer, the
// window feeder (slave) and the PE core side (master).
interface npu_window_feeder_if
  import npu_pkg::*;
#(
  parameter int N          = NPU_N,
  parameter int K_SIZE     = NPU_K_SIZE,
  parameter int DATA_WIDTH = NPU_DATA_WIDTH
);
  localparam int IDX_W = idx_width(N);

  logic                                 col_valid_i;
  logic                                 col_ready_o;
  logic [K_SIZE*DATA_WIDTH-1:0]         col_data_i;
  logic                                 win_valid_o;
  logic                                 win_ready_i;
  logic [K_SIZE*K_SIZE*DATA_WIDTH-1:0]  win_data_o;
  logic [IDX_W-1:0]                     win_idx_o;
  logic                                 win_last_o;

  modport slave (
    input  col_valid_i, col_data_i, win_ready_i,
    output col_ready_o, win_valid_o, win_data_o, win_idx_o, win_last_o
  );

  modport master (
    output col_valid_i, col_data_i, win_ready_i,
    input  col_ready_o, win_valid_o, win_data_o, win_idx_o, win_last_o
  );

endinterface

// File: rtl/npu_col_shiftreg.sv
// K_SIZE-deep column shift register. Column 0 (lowest bits) is the oldest;
// a shift drops it and appends the new column at column K_SIZE-1.
module npu_col_shiftreg
  import npu_pkg::*;
#(
  parameter int K_SIZE     = NPU_K_SIZE,
  parameter int DATA_WIDTH = NPU_DATA_WIDTH
) (
  input  logic                               clk,
  input  logic                               i_clear_n,
  input  logic                               i_shift,
  input  logic [K_SIZE*DATA_WIDTH-1:0]        i_col,
  output logic [K_SIZE*K_SIZE*DATA_WIDTH-1:0] o_win
);
  localparam int COL_W = K_SIZE * DATA_WIDTH;

  logic [K_SIZE*COL_W-1:0] r_win;

  // Shift columns toward index 0 on each accepted column; clear is synchronous.
  always_ff @(posedge clk) begin
    if (!i_clear_n) begin
      r_win <= '0;
    end else if (i_shift) begin
      for (int c = 0; c < K_SIZE - 1; c++) begin
        r_win[c*COL_W +: COL_W] <= r_win[(c+1)*COL_W +: COL_W];
      end
      r_win[(K_SIZE-1)*COL_W +: COL_W] <= i_col;
    end
  end

  assign o_win = r_win;

endmodule

// File: rtl/npu_window_feeder.sv
// Sliding-window feeder: turns a stream of K_SIZE-pixel columns into
// N stride-1 K_SIZE x K_SIZE windows for the PE core.
//
// state  | meaning
// IDLE   | waiting for start_i; no columns accepted
// FILL   | loading the first K_SIZE columns
// STREAM | presenting windows; one new column per window after the first
// DONE   | one-cycle done_o pulse, then back to IDLE
module npu_window_feeder
  import npu_pkg::*;
#(
  parameter int N          = NPU_N,
  parameter int K_SIZE     = NPU_K_SIZE,
  parameter int DATA_WIDTH = NPU_DATA_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  npu_window_feeder_if.slave bus
);
  localparam int COLS  = N + K_SIZE - 1;
  localparam int CNT_W = $clog2(COLS + 1);
  localparam int IDX_W = idx_width(N);
  localparam int WIN_W = K_SIZE * K_SIZE * DATA_WIDTH;

  feeder_state_t    r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cols_in, w_cols_in_nxt;
  logic [IDX_W-1:0] r_win_idx, w_win_idx_nxt;
  logic             r_win_valid, w_win_valid_nxt;
  logic             w_col_ready;
  logic             w_col_acc;
  logic             w_win_hs;
  logic             w_is_last;
  logic             w_busy;
  logic             w_done;
  logic [WIN_W-1:0] w_win;

  // Column ready depends on win_ready_i in STREAM so a window handshake and
  // the next column can complete in the same cycle; never on col_valid_i.
  always_comb begin
    w_col_ready = 1'b0;
    case (r_state)
      FILL:    w_col_ready = 1'b1;
      STREAM:  w_col_ready = (r_cols_in < CNT_W'(COLS)) &&
                             (!r_win_valid || bus.win_ready_i);
      default: w_col_ready = 1'b0;
    endcase
  end

  assign w_col_acc = bus.col_valid_i & w_col_ready;
  assign w_win_hs  = r_win_valid & bus.win_ready_i;
  assign w_is_last = (r_win_idx == IDX_W'(N - 1));

  // Next-state, counter and window-valid decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_cols_in_nxt   = r_cols_in;
    w_win_idx_nxt   = r_win_idx;
    w_win_valid_nxt = r_win_valid;
    w_busy          = 1'b1;
    w_done          = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (start_i) begin
          w_state_nxt     = FILL;
          w_cols_in_nxt   = '0;
          w_win_idx_nxt   = '0;
          w_win_valid_nxt = 1'b0;
        end
      end
      FILL: begin
        if (w_col_acc) begin
          w_cols_in_nxt = r_cols_in + 1'b1;
          if (r_cols_in == CNT_W'(K_SIZE - 1)) begin
            w_state_nxt     = STREAM;
            w_win_valid_nxt = 1'b1;
          end
        end
      end
      STREAM: begin
        if (w_col_acc) begin
          w_cols_in_nxt   = r_cols_in + 1'b1;
          w_win_valid_nxt = 1'b1;
        end else if (w_win_hs) begin
          w_win_valid_nxt = 1'b0;
        end
        if (w_win_hs) begin
          if (w_is_last) begin
            w_state_nxt = DONE;
          end else begin
            w_win_idx_nxt = r_win_idx + 1'b1;
          end
        end
      end
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Job counters and window-valid flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cols_in   <= '0;
      r_win_idx   <= '0;
      r_win_valid <= 1'b0;
    end else begin
      r_cols_in   <= w_cols_in_nxt;
      r_win_idx   <= w_win_idx_nxt;
      r_win_valid <= w_win_valid_nxt;
    end
  end

  npu_col_shiftreg #(
    .K_SIZE     (K_SIZE),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_col_shiftreg (
    .clk       (clk),
    .i_clear_n (reset),
    .i_shift   (w_col_acc),
    .i_col     (bus.col_data_i),
    .o_win     (w_win)
  );

  assign busy_o          = w_busy;
  assign done_o          = w_done;
  assign bus.col_ready_o = w_col_ready;
  assign bus.win_valid_o = r_win_valid;
  assign bus.win_data_o  = w_win;
  assign bus.win_idx_o   = r_win_idx;
  assign bus.win_last_o  = r_win_valid & w_is_last;

endmodule

// File: tb/tb_npu_window_feeder.sv
// Scoreboard bench for npu_window_feeder: expected windows are queued when a
// job is launched and popped by a monitor on every window handshake.
module tb_npu_window_feeder;
  localparam int N    = 10;
  localparam int K    = 3;
  localparam int DW   = 8;
  localparam int COLS = N + K - 1;
  localparam int CW   = K * DW;
  localparam int WW   = K * K * DW;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic busy, done;
  logic start2 = 1'b0;
  logic busy2, done2;

  npu_window_feeder_if #(.N(N), .K_SIZE(K), .DATA_WIDTH(DW)) b1 ();
  npu_window_feeder_if #(.N(1), .K_SIZE(K), .DATA_WIDTH(DW)) b2 ();

  npu_window_feeder #(.N(N), .K_SIZE(K), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start_i(start), .busy_o(busy), .done_o(done), .bus(b1)
  );

  npu_window_feeder #(.N(1), .K_SIZE(K), .DATA_WIDTH(DW)) dut2 (
    .clk(clk), .reset(reset), .start_i(start2), .busy_o(busy2), .done_o(done2), .bus(b2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WW-1:0] data;
    logic [3:0]    idx;
    logic          last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Column c row r carries base + c*K + r.
  function automatic logic [CW-1:0] col_word(input int base, input int c);
    logic [CW-1:0] v;
    for (int r = 0; r < K; r++) v[r*DW +: DW] = 8'(base + c*K + r);
    return v;
  endfunction

  // Window w byte j = column (w + j/K) row (j%K) = base + w*K + j.
  function automatic logic [WW-1:0] exp_win(input int base, input int w);
    logic [WW-1:0] v;
    for (int j = 0; j < K*K; j++) v[j*DW +: DW] = 8'(base + w*K + j);
    return v;
  endfunction

  // Monitor: every window handshake consumes one scoreboard entry.
  always @(negedge clk) begin
    if (reset && b1.win_valid_o && b1.win_ready_i) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("win_data", b1.win_data_o, mon_e.data);
        check("win_idx",  b1.win_idx_o,  mon_e.idx);
        check("win_last", b1.win_last_o, mon_e.last);
      end
    end
  end

  task automatic run_job(input int base, input bit gaps, input int bp_win,
                         input int abort_win, input bit ctl_pulses);
    int c, hs, bp_cnt, acc_cyc, last_cyc, n_exp;
    bit done_seen, first_seen, drop_seen, fin;
    logic [WW-1:0] snap_d;
    logic          snap_l;
    bit pat[4];
    exp_t e;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    c = 0; hs = 0; bp_cnt = 0; acc_cyc = -10; last_cyc = -10;
    done_seen = 0; first_seen = 0; drop_seen = 0; fin = 0;
    snap_d = '0; snap_l = 1'b0;
    n_exp = (abort_win >= 0) ? abort_win + 1 : N;
    for (int w = 0; w < n_exp; w++) begin
      e.data = exp_win(base, w);
      e.idx  = 4'(w);
      e.last = (w == N - 1);
      sb.push_back(e);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      b1.col_valid_i = (c < COLS) && (!gaps || pat[cyc % 4]);
      b1.col_data_i  = col_word(base, c);
      b1.win_ready_i = !(bp_win >= 0 && b1.win_valid_o &&
                         b1.win_idx_o == 4'(bp_win) && bp_cnt < 5);
      start = ctl_pulses && (done || (b1.win_valid_o && b1.win_idx_o == 4'd5));
      @(negedge clk);
      if (done_seen) begin
        check("done_pulse_len", done, 0);
        check("idle_after_done", busy, 0);
        check("idle_col_ready", b1.col_ready_o, 0);
        fin = 1;
      end else begin
        if (b1.win_valid_o && !first_seen) begin
          first_seen = 1;
          check("first_valid_latency", cyc - acc_cyc, 1);
        end
        if (!b1.win_ready_i) begin
          check("stall_col_ready", b1.col_ready_o, 0);
          check("stall_idx", b1.win_idx_o, bp_win);
          if (bp_cnt == 0) begin
            snap_d = b1.win_data_o;
            snap_l = b1.win_last_o;
            check("stall_data_first", b1.win_data_o, exp_win(base, bp_win));
          end else begin
            check("stall_data_stable", b1.win_data_o, snap_d);
            check("stall_last_stable", b1.win_last_o, snap_l);
          end
          bp_cnt++;
        end
        if (busy && hs > 0 && hs < N && !b1.win_valid_o) drop_seen = 1;
        if (b1.col_valid_i && b1.col_ready_o) begin
          c++;
          if (c == K) acc_cyc = cyc;
        end
        if (b1.win_valid_o && b1.win_ready_i) begin
          hs++;
          if (b1.win_last_o) last_cyc = cyc;
        end
        if (done) begin
          done_seen = 1;
          check("done_after_last", cyc - last_cyc, 1);
        end
        if (abort_win >= 0 && hs == abort_win + 1) begin
          @(posedge clk); #1;
          reset = 1'b0;
          b1.win_ready_i = 1'b0;
          b1.col_valid_i = 1'b0;
          @(posedge clk);
          @(negedge clk);
          check("abort_busy", busy, 0);
          check("abort_done", done, 0);
          check("abort_col_ready", b1.col_ready_o, 0);
          check("abort_win_valid", b1.win_valid_o, 0);
          check("abort_win_data", b1.win_data_o, 0);
          check("abort_win_idx", b1.win_idx_o, 0);
          check("abort_win_last", b1.win_last_o, 0);
          reset = 1'b1;
          @(posedge clk);
          @(negedge clk);
          check("abort_no_done", done, 0);
          check("abort_stays_idle", busy, 0);
          fin = 1;
        end
      end
      if (!fin) begin
        @(posedge clk); #1;
      end
    end
    if (!fin) check("job_timeout", 1, 0);
    if (abort_win < 0) begin
      check("win_count", hs, N);
      check("cols_consumed", c, COLS);
      check("done_seen", done_seen, 1);
    end
    if (gaps) check("valid_drop_seen", drop_seen, 1);
    if (bp_win >= 0) check("stall_cycles", bp_cnt, 5);
    check("sb_empty", sb.size(), 0);
    @(posedge clk); #1;
    start = 1'b0;
    b1.col_valid_i = 1'b0;
    b1.win_ready_i = 1'b1;
  endtask

  initial begin
    int c2, got;
    bit done2_seen;
    b1.col_valid_i = 1'b0; b1.col_data_i = '0; b1.win_ready_i = 1'b0;
    b2.col_valid_i = 1'b0; b2.col_data_i = '0; b2.win_ready_i = 1'b0;

    // Reset held with random inputs.
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start          = 1'($urandom_range(0, 1));
      b1.col_valid_i = 1'($urandom_range(0, 1));
      b1.win_ready_i = 1'($urandom_range(0, 1));
      b1.col_data_i  = CW'($urandom);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_col_ready", b1.col_ready_o, 0);
    check("rst_win_valid", b1.win_valid_o, 0);
    check("rst_win_data", b1.win_data_o, 0);
    check("rst_win_idx", b1.win_idx_o, 0);
    check("rst_win_last", b1.win_last_o, 0);
    start = 1'b0; b1.col_valid_i = 1'b1; b1.win_ready_i = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_col_ready", b1.col_ready_o, 0);
    @(posedge clk); #1;
    b1.col_valid_i = 1'b0;

    run_job(0,   1'b0, -1, -1, 1'b1);  // streaming + ignored start pulses
    run_job(30,  1'b0,  2, -1, 1'b0);  // backpressure at window 2
    run_job(60,  1'b1, -1, -1, 1'b0);  // input gaps 1,0,0,1
    run_job(90,  1'b0, -1,  4, 1'b0);  // reset after window 4
    run_job(150, 1'b0, -1, -1, 1'b0);  // fresh job after abort

    // Single-window build.
    c2 = 0; got = 0; done2_seen = 0;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int cyc = 0; cyc < 50 && !done2_seen; cyc++) begin
      b2.col_valid_i = (c2 < K);
      b2.col_data_i  = col_word(50, c2);
      b2.win_ready_i = 1'b1;
      @(negedge clk);
      if (b2.col_valid_i && b2.col_ready_o) c2++;
      if (b2.win_valid_o) begin
        got++;
        check("n1_win_data", b2.win_data_o, exp_win(50, 0));
        check("n1_win_idx", b2.win_idx_o, 0);
        check("n1_win_last", b2.win_last_o, 1);
      end
      if (done2) begin
        done2_seen = 1;
        check("n1_windows_before_done", got, 1);
      end
      @(posedge clk); #1;
    end
    check("n1_done_seen", done2_seen, 1);
    check("n1_cols", c2, K);
    b2.col_valid_i = 1'b0;
    @(negedge clk);
    check("n1_idle", busy2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
